// File: rtl/addsub_pkg.sv
// Shared types and constants for the 4-bit add/sub sequencer and its register file.
package addsub_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LDI = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_e;

  // V compares against the operand the stage actually adds, i.e. B after the mode inversion.
  function automatic logic [FLAG_W-1:0] calc_flags(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic              m,
                                                   input logic [DATA_W-1:0] result,
                                                   input logic              carry);
    logic [DATA_W-1:0] bp;
    logic [FLAG_W-1:0] f;
    bp        = b ^ {DATA_W{m}};
    f         = '0;
    f[FLAG_N] = result[DATA_W-1];
    f[FLAG_Z] = (result == '0);
    f[FLAG_C] = carry;
    f[FLAG_V] = (a[DATA_W-1] == bp[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
    return f;
  endfunction

endpackage

// File: rtl/addsub_regfile.sv
// NREG x 4-bit register file: two operand read ports, a debug read port, one write port.
module addsub_regfile
  import addsub_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     raddr_d,
  output logic [DATA_W-1:0] rdata_d
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/addsub_operand_sequencer.sv
// Command sequencer around the external 4-bit add/sub stage: IDLE accepts and reads operands,
// EXEC samples the stage, WB writes back and updates flags.
module addsub_operand_sequencer
  import addsub_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AW-1:0]     cmd_dst,
  input  logic [AW-1:0]     cmd_srca,
  input  logic [AW-1:0]     cmd_srcb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] stage_av,
  output logic [DATA_W-1:0] stage_bv,
  output logic              stage_m,
  input  logic [DATA_W-1:0] stage_result,
  input  logic              stage_cout,
  output logic              done,
  output logic [FLAG_W-1:0] flags,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [AW-1:0]     dst_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] av_q, bv_q;
  logic              m_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic [FLAG_W-1:0] flags_q;

  logic              accept;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  op_e               cmd_op_e;

  assign cmd_op_e = op_e'(cmd_op);

  addsub_regfile #(
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (dst_q),
    .wdata   (wdata),
    .raddr_a (cmd_srca),
    .rdata_a (rdata_a),
    .raddr_b (cmd_srcb),
    .rdata_b (rdata_b),
    .raddr_d (rd_addr),
    .rdata_d (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    we        = 1'b0;
    wdata     = result_q;
    unique case (state_q)
      IDLE: begin
        cmd_ready = ~reset;
        if (cmd_valid) state_d = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        done    = 1'b1;
        we      = (op_q != OP_CMP);
        wdata   = (op_q == OP_LDI) ? imm_q : result_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == IDLE) && cmd_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      dst_q    <= '0;
      imm_q    <= '0;
      av_q     <= '0;
      bv_q     <= '0;
      m_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      // Operands are read at accept time, so dst==src uses the pre-write value.
      if (accept) begin
        op_q  <= cmd_op_e;
        dst_q <= cmd_dst;
        imm_q <= cmd_imm;
        av_q  <= rdata_a;
        bv_q  <= rdata_b;
        m_q   <= (cmd_op_e == OP_SUB) || (cmd_op_e == OP_CMP);
      end
      if (state_q == EXEC) begin
        result_q <= stage_result;
        carry_q  <= stage_cout;
      end
      if ((state_q == WB) && (op_q != OP_LDI)) begin
        flags_q <= calc_flags(av_q, bv_q, m_q, result_q, carry_q);
      end
    end
  end

  assign stage_av = av_q;
  assign stage_bv = bv_q;
  assign stage_m  = m_q;
  assign flags    = flags_q;

endmodule
